sd_timeout_watchdog: RTL and testbench
======================================

// Module: sd_timeout_watchdog
// PURPOSE
//   Avalon-MM slave watchdog for SD card transactions. It sits directly downstream of the interval timer.
//   - Consumes the timer's irq output as a tick source (one tick per timer period, e.g. 1 ms).
//   - Counts ticks while an SD transaction is armed.
//   - On reaching LIMIT, raises irq and emits a one-cycle abort pulse to the SD controller.
// PARAMETERS
//   CNT_W          16   width of tick counter and limit register (1..16)
//   DEFAULT_LIMIT  250  reset value of limit register (ticks)
// PORTS
//   clk             in   1      system clock; only clock
//   reset           in   1      asynchronous, active-high reset
//   address         in   3      register select
//   chipselect      in   1      slave select
//   write_n         in   1      active-low write strobe
//   writedata       in   16     write data
//   readdata        out  16     registered read data
//   tick_in         in   1      timer irq level; each rising edge = one tick
//   busy_in         in   1      SD controller transaction in progress
//   timeout_abort   out  1      one-cycle pulse on expiry
//   irq             out  1      timeout & irq_enable
// BEHAVIOUR
//   - Reset: all outputs 0; state=IDLE; count=0; limit=DEFAULT_LIMIT; control=0; status=0.
//   - Write strobe: wr = chipselect & ~write_n.
//   - readdata: updated every clock from the address mux; 1-cycle latency.
//   - Unused addresses and unused bits read as 0.
//   - Register map:
//     - 0 STATUS: b0 timeout, b1 done, b2 armed (read-only). Any write clears b0 and b1.
//     - 1 CONTROL: b0 irq_en, b1 auto_arm (both stored). b2 START, b3 STOP are strobes, read as 0.
//     - 2 LIMIT: [CNT_W-1:0]. Takes effect immediately.
//     - 3 KICK: any write sets count to 0.
//     - 4 COUNT: read-only, current count.
//   - Tick detect: tick_edge = tick_in & ~tick_d (tick_d is a registered copy of tick_in).
//   - busy edges: busy_rise and busy_fall are detected the same way from busy_d.
//   - FSM states IDLE, ARMED, EXPIRED:
//     - IDLE -> ARMED on (START & ~STOP) or (auto_arm & busy_rise); count<=0.
//       - Arming is ignored when LIMIT==0.
//     - ARMED:
//       - On tick_edge: count<=count+1, saturating at all-ones.
//       - If count+1 >= LIMIT: go to EXPIRED, timeout<=1, timeout_abort=1 for that cycle.
//       - ARMED -> IDLE on STOP (no flags set).
//       - ARMED -> IDLE on busy_fall with auto_arm (done<=1).
//     - EXPIRED -> IDLE on STOP, or on a STATUS write.
//       - count holds its value for inspection until the next arm.
//   - Simultaneous events:
//     - START+STOP in one write: STOP wins.
//     - KICK + expiring tick_edge: KICK wins (count=0, no expiry).
//     - STATUS clear + timeout event: event wins (flag stays 1).
//     - busy_fall + expiring tick: timeout wins; done not set.
//     - LIMIT written below count while ARMED: expires on the next tick_edge.
//   - Reset mid-operation: immediate IDLE; a pending abort pulse is dropped.
//   - timeout_abort is never high for more than one cycle per expiry.
// CONFIGURATION
//   SD_WDT_TICK_SYNC_EN
//     - Defined: tick_in and busy_in pass through 2-flop synchronisers (reset 0) before edge detect.
//       Adds 2 cycles of detect latency; use when the timer or SD controller runs on a different clock.
//     - Undefined: inputs are used directly. Edge detect then adds 1 cycle of latency.
// TESTING
//   1. Reset -> readdata=0, irq=0, timeout_abort=0. Read addr 2 -> 250 (0x00FA) on the next cycle.
//   2. LIMIT=3, CONTROL=0x5 (ie+START), 3 tick pulses -> after the 3rd edge: abort pulse 1 cycle,
//      STATUS=0x1, irq=1, COUNT=3. Write STATUS -> irq=0, state IDLE.
//   3. LIMIT=4, arm, 3 ticks, KICK, 3 ticks -> no expiry, COUNT=3. Then KICK and a tick edge
//      in the same cycle -> COUNT=0.
//   4. CONTROL=0x3 (auto_arm, ie), busy_in 0->1, 2 ticks, busy_in 1->0 (LIMIT=5)
//      -> STATUS=0x2, irq=0, no abort.
//   5. LIMIT=0, START -> STATUS.armed stays 0. CONTROL=0xC -> stays IDLE.
//      Assert reset while ARMED with count=2 -> COUNT=0, outputs 0.
//   6. With SD_WDT_TICK_SYNC_EN: LIMIT=1, arm, tick rises at cycle N
//      -> abort asserted at cycle N+3 (vs N+1 without the macro).

Source files
------------

// File: rtl/sd_timeout_watchdog_if.sv
// Avalon-MM register bus bundle for the SD timeout watchdog.
// The master drives address/strobes/data; the slave returns registered readdata.
interface sd_timeout_watchdog_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sd_timeout_watchdog.sv
// SD transaction timeout watchdog.
// Counts interval-timer ticks while an SD transaction is armed. When the
// count reaches LIMIT it latches a timeout flag, raises irq (if enabled)
// and fires a one-cycle abort pulse towards the SD controller.
// Optional build macro: SD_WDT_TICK_SYNC_EN puts 2-flop synchronisers on
// tick_in and busy_in for use when those come from another clock domain.
module sd_timeout_watchdog #(
    parameter int CNT_W         = 16,
    parameter int DEFAULT_LIMIT = 250
) (
    input  logic                  clk,
    input  logic                  reset,
    sd_timeout_watchdog_if.slave  bus,
    input  logic                  tick_in,
    input  logic                  busy_in,
    output logic                  timeout_abort,
    output logic                  irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   limit_q;
    logic               irqEn_q;
    logic               autoArm_q;
    logic               timeout_q;
    logic               done_q;
    logic               abort_q;
    logic [15:0]        readdata_q;
    logic               tickDly_q;
    logic               busyDly_q;

    logic               tickS;
    logic               busyS;
    logic               wr;
    logic               statusWr;
    logic               ctrlWr;
    logic               limitWr;
    logic               kickWr;
    logic               startCmd;
    logic               stopCmd;
    logic               tickEdge;
    logic               busyRise;
    logic               busyFall;
    logic               armReq;
    logic [CNT_W:0]     countInc;
    logic [CNT_W-1:0]   countSat;
    logic               expireHit;
    logic [15:0]        readMux;

`ifdef SD_WDT_TICK_SYNC_EN
    logic [1:0] tickSync_q;
    logic [1:0] busySync_q;

    // Two-stage synchronisers so tick/busy from a foreign clock are safe to edge-detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tickSync_q <= 2'b00;
            busySync_q <= 2'b00;
        end else begin
            tickSync_q <= {tickSync_q[0], tick_in};
            busySync_q <= {busySync_q[0], busy_in};
        end
    end

    assign tickS = tickSync_q[1];
    assign busyS = busySync_q[1];
`else
    assign tickS = tick_in;
    assign busyS = busy_in;
`endif

    assign wr       = bus.chipselect & ~bus.write_n;
    assign statusWr = wr && (bus.address == 3'd0);
    assign ctrlWr   = wr && (bus.address == 3'd1);
    assign limitWr  = wr && (bus.address == 3'd2);
    assign kickWr   = wr && (bus.address == 3'd3);
    assign startCmd = ctrlWr & bus.writedata[2];
    assign stopCmd  = ctrlWr & bus.writedata[3];

    assign tickEdge = tickS & ~tickDly_q;
    assign busyRise = busyS & ~busyDly_q;
    assign busyFall = ~busyS & busyDly_q;

    assign armReq    = (startCmd & ~stopCmd) | (autoArm_q & busyRise);
    assign countInc  = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    assign countSat  = countInc[CNT_W] ? count_q : countInc[CNT_W-1:0];
    assign expireHit = countInc >= {1'b0, limit_q};

    // Previous-cycle copies of tick and busy for rising/falling edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tickDly_q <= 1'b0;
            busyDly_q <= 1'b0;
        end else begin
            tickDly_q <= tickS;
            busyDly_q <= busyS;
        end
    end

    // Software-visible configuration: control enables and the tick limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqEn_q   <= 1'b0;
            autoArm_q <= 1'b0;
            limit_q   <= CNT_W'(DEFAULT_LIMIT);
        end else begin
            if (ctrlWr) begin
                irqEn_q   <= bus.writedata[0];
                autoArm_q <= bus.writedata[1];
            end
            if (limitWr) begin
                limit_q <= bus.writedata[CNT_W-1:0];
            end
        end
    end

    // Watchdog FSM with tick counter, sticky status flags and the abort pulse;
    // flag clears come first so a same-cycle setting event overrides them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            if (statusWr) begin
                timeout_q <= 1'b0;
                done_q    <= 1'b0;
            end
            if (kickWr) begin
                count_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (armReq && (limit_q != '0)) begin
                        state_q <= ARMED;
                        count_q <= '0;
                    end
                end
                ARMED: begin
                    if (stopCmd) begin
                        state_q <= IDLE;
                    end else if (tickEdge && !kickWr && expireHit) begin
                        state_q   <= EXPIRED;
                        count_q   <= countSat;
                        timeout_q <= 1'b1;
                        abort_q   <= 1'b1;
                    end else begin
                        if (tickEdge && !kickWr) begin
                            count_q <= countSat;
                        end
                        if (busyFall && autoArm_q) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    if (stopCmd || statusWr) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Register read mux; unmapped addresses and bits return zero
    always_comb begin
        readMux = 16'h0000;
        case (bus.address)
            3'd0:    readMux[2:0] = {(state_q == ARMED), done_q, timeout_q};
            3'd1:    readMux[1:0] = {autoArm_q, irqEn_q};
            3'd2:    readMux[CNT_W-1:0] = limit_q;
            3'd4:    readMux[CNT_W-1:0] = count_q;
            default: readMux = 16'h0000;
        endcase
    end

    // Read data is registered, giving one cycle of read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= 16'h0000;
        end else begin
            readdata_q <= readMux;
        end
    end

    assign bus.readdata  = readdata_q;
    assign timeout_abort = abort_q;
    assign irq           = timeout_q & irqEn_q;

endmodule

// File: tb/tb_sd_timeout_watchdog.sv
// Testbench for sd_timeout_watchdog: directed register/tick sequences with
// register reads checked through an expected-value queue by a monitor.
module tb_sd_timeout_watchdog;

`ifdef SD_WDT_TICK_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    localparam logic [2:0] A_STATUS = 3'd0;
    localparam logic [2:0] A_CTRL   = 3'd1;
    localparam logic [2:0] A_LIMIT  = 3'd2;
    localparam logic [2:0] A_KICK   = 3'd3;
    localparam logic [2:0] A_COUNT  = 3'd4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick_in = 1'b0;
    logic busy_in = 1'b0;
    logic timeout_abort;
    logic irq;

    int total = 0;
    int bad = 0;
    int abortCount = 0;
    int abortBase;
    int lat;
    logic prevAbort = 1'b0;
    logic rdFlag = 1'b0;
    logic [15:0] expQ[$];
    string nameQ[$];

    sd_timeout_watchdog_if bus();

    sd_timeout_watchdog #(
        .CNT_W(16),
        .DEFAULT_LIMIT(250)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .tick_in(tick_in),
        .busy_in(busy_in),
        .timeout_abort(timeout_abort),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Marks cycles where a read was presented so the monitor knows readdata is valid
    always @(posedge clk or posedge reset) begin
        if (reset) rdFlag <= 1'b0;
        else       rdFlag <= bus.chipselect & bus.write_n;
    end

    // Monitor: pops expected read values and watches abort pulse width
    always @(negedge clk) begin
        logic [15:0] e;
        string n;
        if (rdFlag) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_read: got 0x%0h expected no read", bus.readdata);
            end else begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                checkOutput(n, bus.readdata, e);
            end
        end
        if (timeout_abort === 1'b1) begin
            abortCount++;
            total++;
            if (prevAbort) begin
                bad++;
                $display("[TB] FAIL abort_width: got high 2 cycles expected 1");
            end
        end
        prevAbort = (timeout_abort === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [15:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic readExpect(input logic [2:0] addr, input logic [15:0] exp, input string name);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        expQ.push_back(exp);
        nameQ.push_back(name);
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        idle(1);
    endtask

    task automatic tickPulse(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            idle(1);
            tick_in = 1'b0;
            idle(SYNC_LAT + 2);
        end
    endtask

    initial begin
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 16'h0000;
        idle(3);
        checkOutput("reset_readdata", bus.readdata, 16'h0000);
        checkOutput("reset_irq", {15'd0, irq}, 16'h0000);
        checkOutput("reset_abort", {15'd0, timeout_abort}, 16'h0000);
        reset = 1'b0;
        idle(2);
        readExpect(A_LIMIT, 16'h00FA, "default_limit");

        // Basic expiry with irq enabled
        abortBase = abortCount;
        applyStimulus(A_LIMIT, 16'd3);
        applyStimulus(A_CTRL, 16'h0005);
        readExpect(A_STATUS, 16'h0004, "t2_armed");
        tickPulse(3);
        checkOutput("t2_abort_count", 16'(abortCount - abortBase), 16'd1);
        checkOutput("t2_irq", {15'd0, irq}, 16'h0001);
        readExpect(A_STATUS, 16'h0001, "t2_status");
        readExpect(A_COUNT, 16'd3, "t2_count");
        readExpect(A_CTRL, 16'h0001, "t2_ctrl");
        applyStimulus(A_STATUS, 16'h0000);
        checkOutput("t2_irq_cleared", {15'd0, irq}, 16'h0000);
        readExpect(A_STATUS, 16'h0000, "t2_idle");

        // KICK restarts the count; KICK beats a same-cycle expiring tick
        abortBase = abortCount;
        applyStimulus(A_LIMIT, 16'd4);
        applyStimulus(A_CTRL, 16'h0005);
        tickPulse(3);
        applyStimulus(A_KICK, 16'h0000);
        tickPulse(3);
        readExpect(A_COUNT, 16'd3, "t3_count");
        tick_in = 1'b1;
        repeat (SYNC_LAT) idle(1);
        applyStimulus(A_KICK, 16'h0000);
        tick_in = 1'b0;
        idle(SYNC_LAT + 2);
        readExpect(A_COUNT, 16'd0, "t3_kick_wins");
        readExpect(A_STATUS, 16'h0004, "t3_still_armed");
        checkOutput("t3_no_abort", 16'(abortCount - abortBase), 16'd0);
        applyStimulus(A_CTRL, 16'h0009);
        readExpect(A_STATUS, 16'h0000, "t3_stopped");

        // Auto-arm follows busy; busy falling before expiry sets done
        abortBase = abortCount;
        applyStimulus(A_LIMIT, 16'd5);
        applyStimulus(A_CTRL, 16'h0003);
        busy_in = 1'b1;
        idle(SYNC_LAT + 2);
        readExpect(A_STATUS, 16'h0004, "t4_auto_armed");
        tickPulse(2);
        busy_in = 1'b0;
        idle(SYNC_LAT + 2);
        readExpect(A_STATUS, 16'h0002, "t4_done");
        readExpect(A_COUNT, 16'd2, "t4_count");
        checkOutput("t4_irq", {15'd0, irq}, 16'h0000);
        checkOutput("t4_no_abort", 16'(abortCount - abortBase), 16'd0);
        applyStimulus(A_STATUS, 16'h0000);
        applyStimulus(A_CTRL, 16'h0000);
        readExpect(A_STATUS, 16'h0000, "t4_cleared");

        // LIMIT lowered below count while armed; irq masked
        abortBase = abortCount;
        applyStimulus(A_LIMIT, 16'd10);
        applyStimulus(A_CTRL, 16'h0004);
        tickPulse(3);
        applyStimulus(A_LIMIT, 16'd2);
        readExpect(A_STATUS, 16'h0004, "lim_still_armed");
        tickPulse(1);
        checkOutput("lim_abort_count", 16'(abortCount - abortBase), 16'd1);
        readExpect(A_STATUS, 16'h0001, "lim_expired");
        readExpect(A_COUNT, 16'd4, "lim_count");
        checkOutput("lim_irq_masked", {15'd0, irq}, 16'h0000);
        applyStimulus(A_CTRL, 16'h0008);
        readExpect(A_STATUS, 16'h0001, "lim_stop_keeps_flag");
        applyStimulus(A_STATUS, 16'h0000);
        readExpect(A_STATUS, 16'h0000, "lim_cleared");

        // Arming blocked by LIMIT=0 and by START+STOP
        applyStimulus(A_LIMIT, 16'd0);
        applyStimulus(A_CTRL, 16'h0004);
        readExpect(A_STATUS, 16'h0000, "t5_limit0");
        applyStimulus(A_LIMIT, 16'd3);
        applyStimulus(A_CTRL, 16'h000C);
        readExpect(A_STATUS, 16'h0000, "t5_stop_wins");
        readExpect(A_CTRL, 16'h0000, "t5_strobes_read0");
        readExpect(3'd6, 16'h0000, "t5_unused_addr");

        // Reset while armed mid-count
        applyStimulus(A_CTRL, 16'h0004);
        tickPulse(2);
        readExpect(A_COUNT, 16'd2, "t5_count_pre_reset");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_reset_readdata", bus.readdata, 16'h0000);
        checkOutput("t5_reset_abort", {15'd0, timeout_abort}, 16'h0000);
        checkOutput("t5_reset_irq", {15'd0, irq}, 16'h0000);
        idle(1);
        reset = 1'b0;
        idle(1);
        readExpect(A_COUNT, 16'd0, "t5_count_after_reset");
        readExpect(A_STATUS, 16'h0000, "t5_status_after_reset");
        readExpect(A_LIMIT, 16'h00FA, "t5_limit_after_reset");

        // Tick-to-abort latency
        applyStimulus(A_LIMIT, 16'd1);
        applyStimulus(A_CTRL, 16'h0004);
        tick_in = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            lat++;
            if (timeout_abort === 1'b1) break;
        end
        checkOutput("t6_abort_latency", 16'(lat), 16'(1 + SYNC_LAT));
        tick_in = 1'b0;
        idle(SYNC_LAT + 2);
        readExpect(A_STATUS, 16'h0001, "t6_status");
        applyStimulus(A_STATUS, 16'h0000);
        readExpect(A_STATUS, 16'h0000, "t6_cleared");

        idle(4);
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
